// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with PC, one-entry hold buffer and redirect handling.
//   clk, rst (sync, active-low)
//   imem_address/imem_read -> single-beat request, held until imem_resp
//   imem_rdata/imem_resp   <- instruction word with a one-cycle response pulse
//   stall_in               <- decode cannot accept the slot this cycle
//   redirect_valid/pc      <- taken branch/jump target from execute
//   if_valid/if_pc/if_instr and dec_* -> fetched instruction and pre-sliced fields
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  dec_opcode,
    output logic [4:0]  dec_rd,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state_q, state_d;
    logic        init_q;
    logic        valid_q, valid_d, slot_free;
    logic [31:0] pc_q, pc_d, req_q, req_d;
    logic [31:0] slot_pc_q, slot_pc_d, slot_ins_q, slot_ins_d;
    logic [31:0] hold_pc_q, hold_pc_d, hold_ins_q, hold_ins_d;
    assign slot_free    = !valid_q || !stall_in;
    // init_q delays the first request by one cycle after reset release
    assign imem_read    = rst && init_q && (state_q != HOLD);
    assign imem_address = req_q;
    assign if_valid     = valid_q;
    assign if_pc        = slot_pc_q;
    assign if_instr     = slot_ins_q;
    assign dec_opcode   = slot_ins_q[6:0];
    assign dec_rd       = slot_ins_q[11:7];
    assign dec_funct3   = slot_ins_q[14:12];
    assign dec_funct7   = slot_ins_q[31:25];
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q && stall_in;
        slot_pc_d  = slot_pc_q;
        slot_ins_d = slot_ins_q;
        hold_pc_d  = hold_pc_q;
        hold_ins_d = hold_ins_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end
        case (state_q)
            FETCH: begin
                // an unanswered request cannot be aborted, so its reply must be waited out
                if (init_q && redirect_valid && !imem_resp) begin
                    state_d = DISCARD;
                end else if (init_q && imem_resp && !redirect_valid) begin
                    pc_d = pc_q + 32'd4;
                    if (slot_free) begin
                        slot_pc_d  = pc_q;
                        slot_ins_d = imem_rdata;
                        valid_d    = 1'b1;
                    end else begin
                        hold_pc_d  = pc_q;
                        hold_ins_d = imem_rdata;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid || !stall_in) state_d = FETCH;
                if (!redirect_valid && !stall_in) begin
                    slot_pc_d  = hold_pc_q;
                    slot_ins_d = hold_ins_q;
                    valid_d    = 1'b1;
                end
            end
            DISCARD: if (imem_resp) state_d = FETCH;
            default: state_d = FETCH;
        endcase
        // the address must not move while a discarded request is still outstanding
        req_d = (state_d == DISCARD) ? req_q : {pc_d[31:2], 2'b00};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            init_q     <= 1'b0;
            pc_q       <= RESET_PC;
            req_q      <= {RESET_PC[31:2], 2'b00};
            valid_q    <= 1'b0;
            slot_pc_q  <= '0;
            slot_ins_q <= '0;
            hold_pc_q  <= '0;
            hold_ins_q <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= 1'b1;
            pc_q       <= pc_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            slot_pc_q  <= slot_pc_d;
            slot_ins_q <= slot_ins_d;
            hold_pc_q  <= hold_pc_d;
            hold_ins_q <= hold_ins_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed bench for fetch_stage with a transaction-level reference model.
module tb_fetch_stage;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] imem_address, imem_rdata = '0, redirect_pc = '0;
    logic        imem_read, imem_resp = 1'b0, stall_in = 1'b0, redirect_valid = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic [6:0]  dec_opcode, dec_funct7;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;

    fetch_stage #(.RESET_PC(32'h0000_0060)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 1'b0;
    bit mb = 1'b0, rand_lat = 1'b0;
    int mc = 0, lat = 0;
    logic [31:0] ma = '0;
    logic [31:0] m_pc, m_spc, m_sins, m_saddr;
    bit m_v, m_started, m_stale;
    logic [31:0] m_hq[$];
    logic [31:0] dlv[$];
    int dlv_c[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ {a[7:0], a[31:8]};
    endfunction

    function automatic logic [31:0] al(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic bit seen(input logic [31:0] a);
        foreach (dlv[i]) if (dlv[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: accepts a request when idle, answers `lat` cycles after the request cycle + 1
    task automatic mem_tick();
        imem_resp  = 1'b0;
        imem_rdata = $urandom;
        if (mb) begin
            if (mc == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = word(ma);
                mb = 1'b0;
            end else mc--;
        end else if (imem_read) begin
            mb = 1'b1;
            mc = rand_lat ? int'($urandom_range(0, 3)) : lat;
            ma = imem_address;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        mem_tick();
    endtask

    function automatic bit cond(input int sel, input logic [31:0] a);
        case (sel)
            0: return if_valid;
            1: return imem_resp && imem_address == a;
            2: return imem_read && imem_address == a;
            3: return dlv.size() >= int'(a);
            4: return imem_read && imem_address == a && mb && mc == lat && !imem_resp;
            default: return imem_read && mb && mc == lat && !imem_resp;
        endcase
    endfunction

    task automatic wait_cond(input string name, input int sel, input logic [31:0] a);
        int k = 0;
        while (!cond(sel, a) && k < 100) begin
            next_cycle();
            k++;
        end
        if (k == 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got timeout after 100 cycles expected event (cycle %0d)", name, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        next_cycle();
        chk_en = 1'b1;
        chk("rst_read", 32'(imem_read), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        next_cycle();
        rst = 1'b1;
        mb = 1'b0;
        imem_resp = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
        chk("warm_read", 32'(imem_read), 32'd0);
        chk("warm_valid", 32'(if_valid), 32'd0);
        chk("warm_if_pc", if_pc, 32'd0);
        chk("warm_if_instr", if_instr, 32'd0);
        dlv.delete();
        dlv_c.delete();
    endtask

    task automatic model_step();
        bit nv, fr;
        if (!rst) begin
            m_pc = 32'h60; m_started = 1'b0; m_v = 1'b0; m_spc = '0; m_sins = '0;
            m_hq.delete(); m_stale = 1'b0; m_saddr = '0;
        end else begin
            nv = m_v && stall_in;
            fr = !m_v || !stall_in;
            if (!m_started) begin
                if (redirect_valid) begin m_pc = redirect_pc; nv = 1'b0; end
                m_started = 1'b1;
            end else if (m_hq.size() != 0) begin
                if (redirect_valid) begin m_hq.delete(); m_pc = redirect_pc; nv = 1'b0; end
                else if (!stall_in) begin m_spc = m_hq.pop_front(); m_sins = word(al(m_spc)); nv = 1'b1; end
            end else if (m_stale) begin
                if (redirect_valid) begin m_pc = redirect_pc; nv = 1'b0; end
                if (imem_resp) m_stale = 1'b0;
            end else if (imem_resp) begin
                if (redirect_valid) begin m_pc = redirect_pc; nv = 1'b0; end
                else if (fr) begin m_spc = m_pc; m_sins = word(al(m_pc)); nv = 1'b1; m_pc = m_pc + 32'd4; end
                else begin m_hq.push_back(m_pc); m_pc = m_pc + 32'd4; end
            end else if (redirect_valid) begin
                m_saddr = al(m_pc); m_stale = 1'b1; m_pc = redirect_pc; nv = 1'b0;
            end
            m_v = nv;
        end
    endtask

    always @(negedge clk) begin
        logic e_read;
        logic [31:0] e_addr;
        if (chk_en) begin
            e_read = rst && m_started && m_hq.size() == 0;
            e_addr = m_stale ? m_saddr : al(m_pc);
            chk("imem_read", 32'(imem_read), 32'(e_read));
            if (e_read) chk("imem_address", imem_address, e_addr);
            chk("if_valid", 32'(if_valid), 32'(m_v));
            if (m_v) begin
                chk("if_pc", if_pc, m_spc);
                chk("if_instr", if_instr, m_sins);
                chk("dec_fields", {10'd0, dec_funct7, dec_funct3, dec_rd, dec_opcode},
                    {10'd0, m_sins[31:25], m_sins[14:12], m_sins[11:7], m_sins[6:0]});
            end
            if (if_valid && !stall_in && rst) begin
                dlv.push_back(if_pc);
                dlv_c.push_back(cyc);
            end
        end
        model_step();
    end

    initial begin
        int n0;
        logic [31:0] r;
        do_reset();
        lat = 0;
        next_cycle();
        chk("first_addr", imem_address, 32'h60);
        chk("first_read", 32'(imem_read), 32'd1);
        wait_cond("first_three", 3, 32'd3);
        if (dlv.size() >= 3) begin
            chk("dlv0", dlv[0], 32'h60);
            chk("dlv1", dlv[1], 32'h64);
            chk("dlv2", dlv[2], 32'h68);
            chk("spacing01", 32'(dlv_c[1] - dlv_c[0]), 32'd2);
            chk("spacing12", 32'(dlv_c[2] - dlv_c[1]), 32'd2);
        end
        wait_cond("resp_0x80", 1, 32'h80);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        next_cycle();
        redirect_valid = 1'b0;
        chk("rr_valid", 32'(if_valid), 32'd0);
        chk("rr_read", 32'(imem_read), 32'd1);
        chk("rr_addr", imem_address, 32'h300);
        wait_cond("dlv_0x300", 0, 32'd0);
        chk("rr_if_pc", if_pc, 32'h300);
        chk("rr_dropped", 32'(seen(32'h80)), 32'd0);
        n0 = dlv.size();
        stall_in = 1'b1;
        repeat (3) next_cycle();
        chk("hold_read", 32'(imem_read), 32'd0);
        chk("hold_valid", 32'(if_valid), 32'd1);
        chk("hold_if_pc", if_pc, 32'h300);
        repeat (2) next_cycle();
        stall_in = 1'b0;
        wait_cond("post_hold", 3, 32'(n0 + 2));
        if (dlv.size() >= n0 + 2) begin
            chk("post_hold0", dlv[n0], 32'h300);
            chk("post_hold1", dlv[n0 + 1], 32'h304);
        end
        wait_cond("hold2_valid", 0, 32'd0);
        stall_in = 1'b1;
        repeat (3) next_cycle();
        chk("hold2_read", 32'(imem_read), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        next_cycle();
        redirect_valid = 1'b0;
        stall_in = 1'b0;
        chk("sr_valid", 32'(if_valid), 32'd0);
        chk("sr_read", 32'(imem_read), 32'd1);
        chk("sr_addr", imem_address, 32'h400);
        do_reset();
        lat = 2;
        wait_cond("req_0x70", 4, 32'h70);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        next_cycle();
        redirect_valid = 1'b0;
        chk("disc_addr1", imem_address, 32'h70);
        chk("disc_read1", 32'(imem_read), 32'd1);
        next_cycle();
        chk("disc_addr2", imem_address, 32'h70);
        wait_cond("req_0x200", 2, 32'h200);
        chk("disc_dropped", 32'(seen(32'h70)), 32'd0);
        wait_cond("dlv_0x200", 0, 32'd0);
        chk("disc_if_pc", if_pc, 32'h200);
        wait_cond("fresh_req", 5, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        next_cycle();
        redirect_valid = 1'b0;
        do_reset();
        next_cycle();
        chk("rst_disc_addr", imem_address, 32'h60);
        chk("rst_disc_read", 32'(imem_read), 32'd1);
        rand_lat = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            next_cycle();
            stall_in = ($urandom_range(0, 99) < 35);
            redirect_valid = ($urandom_range(0, 99) < 6);
            r = $urandom;
            redirect_pc = ($urandom_range(0, 9) == 0) ? r :
                          ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : {20'd0, r[11:2], 2'b00};
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
